// File: rtl/adder_seq_arb.sv
`default_nettype none
// ============================================================================
// Module   : adder_seq_arb
// Purpose  : Round-robin shared controller for a 5-bit adder slice. Two
//            requesters (A, B) compete for the slice. The granted add is
//            W = 5*WORDS bits wide and is executed one 5-bit slice per cycle,
//            LSB slice first, with the inter-slice carry held in a flop.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WORDS    number of 5-bit slices per operand (1..16), W = 5*WORDS
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_a/a_i1/a_i2/a_cin   requester A request, operands, carry-in
//   req_b/b_i1/b_i2/b_cin   requester B request, operands, carry-in
//   gnt_a, gnt_b         one-cycle grant pulses (operands captured)
//   busy                 operation in progress (RUN or DONE)
//   done                 one-cycle pulse, sum/cout valid
//   owner                0 = result belongs to A, 1 = B
//   sum, cout            result and final carry, held until the next done
//   ovf                  signed overflow of the completed add (optional)
// Optional feature
//   ADDER_SEQ_OVF_EN     when defined, adds the ovf output port
// ============================================================================
module adder_seq_arb #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_a,
    input  logic [5*WORDS-1:0]   a_i1,
    input  logic [5*WORDS-1:0]   a_i2,
    input  logic                 a_cin,
    input  logic                 req_b,
    input  logic [5*WORDS-1:0]   b_i1,
    input  logic [5*WORDS-1:0]   b_i2,
    input  logic                 b_cin,
    output logic                 gnt_a,
    output logic                 gnt_b,
    output logic                 busy,
    output logic                 done,
    output logic                 owner,
`ifdef ADDER_SEQ_OVF_EN
    output logic                 ovf,
`endif
    output logic [5*WORDS-1:0]   sum,
    output logic                 cout
);

    localparam int W     = 5 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [W-1:0]       op1, op1_d;
    logic [W-1:0]       op2, op2_d;
    logic               carry, carry_d;
    logic [W-1:0]       res, res_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic               last_served, last_served_d;   // 0 = A, 1 = B
    logic               owner_d, gnt_a_d, gnt_b_d, done_d, cout_d;
    logic [W-1:0]       sum_d;
    logic               sel_b;
    logic [5:0]         slice_full;                   // {cout, sum[4:0]} of the slice
    logic [W-1:0]       res_next;                     // result with current slice inserted
`ifdef ADDER_SEQ_OVF_EN
    logic               ovf_d;
`endif

    // The single shared 5-bit slice and the partial result it produces.
    always_comb begin
        slice_full = {1'b0, op1[idx*5 +: 5]} + {1'b0, op2[idx*5 +: 5]} + {5'd0, carry};
        res_next   = res;
        res_next[idx*5 +: 5] = slice_full[4:0];
    end

    // Round robin: on a tie, serve the requester that was not served last.
    assign sel_b = req_b & (~req_a | ~last_served);

    always_comb begin
        state_d       = state;
        op1_d         = op1;
        op2_d         = op2;
        carry_d       = carry;
        res_d         = res;
        idx_d         = idx;
        last_served_d = last_served;
        owner_d       = owner;
        gnt_a_d       = 1'b0;
        gnt_b_d       = 1'b0;
        done_d        = 1'b0;
        sum_d         = sum;
        cout_d        = cout;
`ifdef ADDER_SEQ_OVF_EN
        ovf_d         = ovf;
`endif
        case (state)
            S_IDLE: begin
                if (req_a || req_b) begin
                    op1_d         = sel_b ? b_i1  : a_i1;
                    op2_d         = sel_b ? b_i2  : a_i2;
                    carry_d       = sel_b ? b_cin : a_cin;
                    gnt_a_d       = ~sel_b;
                    gnt_b_d       = sel_b;
                    last_served_d = sel_b;
                    owner_d       = sel_b;
                    res_d         = '0;
                    idx_d         = '0;
                    state_d       = S_RUN;
                end
            end
            S_RUN: begin
                res_d   = res_next;
                carry_d = slice_full[5];
                idx_d   = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    // Only the completed result ever reaches sum/cout.
                    sum_d   = res_next;
                    cout_d  = slice_full[5];
                    done_d  = 1'b1;
`ifdef ADDER_SEQ_OVF_EN
                    ovf_d   = (op1[W-1] == op2[W-1]) && (res_next[W-1] != op1[W-1]);
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op1         <= '0;
            op2         <= '0;
            carry       <= 1'b0;
            res         <= '0;
            idx         <= '0;
            last_served <= 1'b1;     // A wins the first tie
            owner       <= 1'b0;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sum         <= '0;
            cout        <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
            ovf         <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            op1         <= op1_d;
            op2         <= op2_d;
            carry       <= carry_d;
            res         <= res_d;
            idx         <= idx_d;
            last_served <= last_served_d;
            owner       <= owner_d;
            gnt_a       <= gnt_a_d;
            gnt_b       <= gnt_b_d;
            busy        <= (state_d != S_IDLE);
            done        <= done_d;
            sum         <= sum_d;
            cout        <= cout_d;
`ifdef ADDER_SEQ_OVF_EN
            ovf         <= ovf_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_seq_arb
// Purpose  : Self-checking bench for adder_seq_arb (WORDS=4). A transaction
//            level reference model predicts grants, done timing and results
//            from the arbitration rules and plain wide arithmetic.
// Revision : 1.0  initial release
// Optional : ADDER_SEQ_OVF_EN enables the ovf checks
// ============================================================================
module tb_adder_seq_arb;

    localparam int WORDS = 4;
    localparam int W     = 5 * WORDS;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_a, req_b, a_cin, b_cin;
    logic [W-1:0]   a_i1, a_i2, b_i1, b_i2;
    logic           gnt_a, gnt_b, busy, done, owner, cout;
    logic [W-1:0]   sum;
`ifdef ADDER_SEQ_OVF_EN
    logic           ovf;
`endif

    int n_total = 0;
    int n_bad   = 0;

    adder_seq_arb #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req_a (req_a),
        .a_i1  (a_i1),
        .a_i2  (a_i2),
        .a_cin (a_cin),
        .req_b (req_b),
        .b_i1  (b_i1),
        .b_i2  (b_i2),
        .b_cin (b_cin),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .busy  (busy),
        .done  (done),
        .owner (owner),
`ifdef ADDER_SEQ_OVF_EN
        .ovf   (ovf),
`endif
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: sampled on the falling edge. Inputs snapshotted at
    // the previous falling edge are what the DUT saw on the rising edge.
    // ------------------------------------------------------------------
    logic           pa = 1'b0, pb = 1'b0, pac, pbc;
    logic [W-1:0]   pa1, pa2, pb1, pb2;
    int             left = 0;          // edges until the slice is free again
    bit             m_last = 1'b1;     // last served: 0 = A, 1 = B
    logic [W-1:0]   p_sum, e_sum;
    logic           p_cout, e_cout, e_owner, p_ovf, e_ovf;
    bit             e_ga, e_gb, e_done, sel;
    logic [W:0]     full;
    bit             glog[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            left = 0; m_last = 1'b1;
            e_sum = '0; e_cout = 1'b0; e_owner = 1'b0; e_ovf = 1'b0;
            chk("reset_outs", {38'd0, gnt_a, gnt_b, busy, done, cout, owner, sum}, 64'd0);
        end else begin
            e_ga = 1'b0; e_gb = 1'b0; e_done = 1'b0;
            if (left == 0) begin
                if (pa || pb) begin
                    sel = pb && (!pa || !m_last);
                    e_ga = !sel; e_gb = sel;
                    m_last = sel; e_owner = sel;
                    if (sel) full = {1'b0, pb1} + {1'b0, pb2} + {{W{1'b0}}, pbc};
                    else     full = {1'b0, pa1} + {1'b0, pa2} + {{W{1'b0}}, pac};
                    p_sum  = full[W-1:0];
                    p_cout = full[W];
                    if (sel) p_ovf = (pb1[W-1] == pb2[W-1]) && (p_sum[W-1] != pb1[W-1]);
                    else     p_ovf = (pa1[W-1] == pa2[W-1]) && (p_sum[W-1] != pa1[W-1]);
                    left = WORDS + 1;
                    glog.push_back(sel);
                end
            end else begin
                left--;
                if (left == 1) begin
                    e_done = 1'b1;
                    e_sum = p_sum; e_cout = p_cout; e_ovf = p_ovf;
                end
            end
            chk("gnt_a", {63'd0, gnt_a}, {63'd0, e_ga});
            chk("gnt_b", {63'd0, gnt_b}, {63'd0, e_gb});
            chk("done",  {63'd0, done},  {63'd0, e_done});
            chk("busy",  {63'd0, busy},  {63'd0, left != 0});
            chk("result", {42'd0, owner, cout, sum}, {42'd0, e_owner, e_cout, e_sum});
`ifdef ADDER_SEQ_OVF_EN
            chk("ovf", {63'd0, ovf}, {63'd0, e_ovf});
`endif
        end
        pa = req_a; pa1 = a_i1; pa2 = a_i2; pac = a_cin;
        pb = req_b; pb1 = b_i1; pb2 = b_i2; pbc = b_cin;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            default: return W'($urandom);
        endcase
    endfunction

    // Raise a request, hold it until the grant is seen, then drop it.
    // Returns just after the grant edge.
    task automatic req_op(input bit who, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c);
        int n = 0;
        if (!who) begin req_a = 1'b1; a_i1 = x; a_i2 = y; a_cin = c; end
        else      begin req_b = 1'b1; b_i1 = x; b_i2 = y; b_cin = c; end
        do begin
            @(posedge clk); #1; n++;
        end while (!(who ? gnt_b : gnt_a) && n < 200);
        if (n >= 200) chk(who ? "gnt_b_timeout" : "gnt_a_timeout", 64'd0, 64'd1);
        if (!who) req_a = 1'b0; else req_b = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        do begin
            @(posedge clk); #1; edges++;
        end while (!done && edges < 50);
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int e, gap;

    initial begin
        rst_n = 1'b1; req_a = 1'b0; req_b = 1'b0;
        a_i1 = '0; a_i2 = '0; a_cin = 1'b0; b_i1 = '0; b_i2 = '0; b_cin = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single requester, carry ripples through every slice.
        req_op(1'b0, 20'h00001, 20'hFFFFF, 1'b0);
        wait_done(e);
        chk("t1_latency_incl_grant_edge", 64'(e + 1), 64'(WORDS + 1));
        chk("t1_sum",   64'(sum), 64'h0);
        chk("t1_cout",  {63'd0, cout},  64'd1);
        chk("t1_owner", {63'd0, owner}, 64'd0);

        // Tie from reset: A first, B right after the DONE->IDLE cycle.
        @(posedge clk); #1 pulse_reset();
        fork
            req_op(1'b0, 20'h12345, 20'h0ABCD, 1'b1);
            req_op(1'b1, 20'hFFFFF, 20'hFFFFF, 1'b1);
            begin
                wait_done(e);
                chk("tie_a_sum",   64'(sum), 64'h1CF13);
                chk("tie_a_cout",  {63'd0, cout},  64'd0);
                chk("tie_a_owner", {63'd0, owner}, 64'd0);
                wait_done(e);
                chk("tie_b_sum",   64'(sum), 64'hFFFFF);
                chk("tie_b_cout",  {63'd0, cout},  64'd1);
                chk("tie_b_owner", {63'd0, owner}, 64'd1);
            end
        join

        // Continuous requests from both sides: strict alternation.
        repeat (3) @(posedge clk); #1;
        glog.delete();
        fork
            repeat (2) req_op(1'b0, rnd_op(), rnd_op(), 1'($urandom));
            repeat (2) req_op(1'b1, rnd_op(), rnd_op(), 1'($urandom));
        join
        wait_done(e);
        chk("rr_count", 64'(glog.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < glog.size()) chk("rr_order", {63'd0, glog[i]}, 64'(i % 2));

        // Reset in the middle of RUN abandons the operation.
        repeat (2) @(posedge clk); #1;
        req_op(1'b0, 20'h55555, 20'h0AAAA, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {38'd0, gnt_a, gnt_b, busy, done, cout, owner, sum}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_op(1'b0, 20'h00010, 20'h00020, 1'b0);
        wait_done(e);
        chk("post_rst_sum", 64'(sum), 64'h00030);

        // B raises during A's RUN and is served on the first IDLE edge.
        repeat (2) @(posedge clk); #1;
        fork
            req_op(1'b0, rnd_op(), rnd_op(), 1'b1);
            begin repeat (2) @(posedge clk); #1; req_op(1'b1, rnd_op(), rnd_op(), 1'b0); end
            begin
                wait_done(e);
                gap = 0;
                do begin @(posedge clk); #1; gap++; end while (!gnt_b && gap < 20);
                chk("b_pending_gap", 64'(gap), 64'd2);
            end
        join
        wait_done(e);

        // Randomized contention.
        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 8)) @(posedge clk);
                #1 req_op(1'b0, rnd_op(), rnd_op(), 1'($urandom));
            end
            for (int j = 0; j < 25; j++) begin
                repeat ($urandom_range(0, 8)) @(posedge clk);
                #1 req_op(1'b1, rnd_op(), rnd_op(), 1'($urandom));
            end
        join
        repeat (10) @(posedge clk); #1;

`ifdef ADDER_SEQ_OVF_EN
        req_op(1'b0, 20'h7FFFF, 20'h00001, 1'b0);
        wait_done(e);
        chk("ovf_pos_sum", 64'(sum), 64'h80000);
        chk("ovf_pos",     {63'd0, ovf}, 64'd1);
        repeat (2) @(posedge clk); #1;
        req_op(1'b1, 20'hFFFFF, 20'h00001, 1'b0);
        wait_done(e);
        chk("ovf_neg",      {63'd0, ovf},  64'd0);
        chk("ovf_neg_cout", {63'd0, cout}, 64'd1);
        repeat (2) @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
